result_drain_requant: RTL and testbench

Downstream stage of `systolic_array_with_buffers`. It captures the packed `SIZE*SIZE` accumulator matrix on the array's one-cycle `result_valid` pulse, then requantizes each element: a rounding arithmetic right shift followed by signed saturation to `DATA_WIDTH`. It streams only the active `matrix_size x matrix_size` sub-matrix, in row-major order, over a valid/ready interface toward the AXI write-back path. This frees the array to start its next job while results drain.

---
 rtl/sa_pkg.sv | 30 +++
 rtl/requant_sat.sv | 49 ++++
 rtl/result_drain_requant.sv | 190 +++++++++++++++++++
 tb/tb_result_drain_requant.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sa_pkg : shared types and helpers for the systolic-array result path
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package sa_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    function automatic int acc_width(input int data_width);
        return 3 * data_width;
    endfunction

    function automatic int elem_idx(input int r, input int c, input int size);
        return r * size + c;
    endfunction

    function automatic int sat_max(input int data_width);
        return (1 << (data_width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int data_width);
        return -(1 << (data_width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/requant_sat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// requant_sat : rounding arithmetic right shift plus signed saturation
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module requant_sat
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH),
    parameter int SHIFT_W    = $clog2(ACC_WIDTH)
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [SHIFT_W-1:0]    shift,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  sat
);

    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] C_MAX = EW'(sat_max(DATA_WIDTH));
    localparam logic signed [EW-1:0] C_MIN = EW'(sat_min(DATA_WIDTH));
    localparam logic signed [EW-1:0] C_ONE = EW'(1);

    logic signed [EW-1:0] w_ext;
    logic signed [EW-1:0] w_bias;
    logic signed [EW-1:0] w_t;

    always_comb begin
        w_ext  = $signed({acc[ACC_WIDTH-1], acc});
        w_bias = '0;
        // A zero shift leaves the bias at zero, so t collapses to a.
        if (shift != '0) begin
            w_bias = C_ONE <<< (shift - SHIFT_W'(1));
        end
        w_t = (w_ext + w_bias) >>> shift;

        q   = w_t[DATA_WIDTH-1:0];
        sat = 1'b0;
        if (w_t > C_MAX) begin
            q   = C_MAX[DATA_WIDTH-1:0];
            sat = 1'b1;
        end else if (w_t < C_MIN) begin
            q   = C_MIN[DATA_WIDTH-1:0];
            sat = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_drain_requant.sv
`default_nettype none
// ---------------------------------------------------------------------------
// result_drain_requant : captures an accumulator matrix and streams the
// requantized active sub-matrix row-major over valid/ready
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module result_drain_requant
    import sa_pkg::*;
#(
    parameter int SIZE       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [SIZE*SIZE*ACC_WIDTH-1:0] in_matrix,
    input  logic [$clog2(SIZE+1)-1:0]      in_size,
    input  logic [$clog2(ACC_WIDTH)-1:0]   shift_amt,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           out_sat,
    output logic                           busy,
    output logic                           dropped
);

    localparam int SZ_W = $clog2(SIZE + 1);
    localparam int SH_W = $clog2(ACC_WIDTH);
    localparam int NE   = SIZE * SIZE;
    localparam int IX_W = (NE > 1) ? $clog2(NE) : 1;
    localparam logic [SZ_W-1:0] C_SIZE   = SZ_W'(SIZE);
    localparam logic [SH_W-1:0] C_SH_MAX = SH_W'(ACC_WIDTH - 1);

    drain_state_t              state_q,   state_d;
    logic [NE*ACC_WIDTH-1:0]   matrix_q,  matrix_d;
    logic [SZ_W-1:0]           size_q,    size_d;
    logic [SH_W-1:0]           shift_q,   shift_d;
    logic [SZ_W-1:0]           row_q,     row_d;
    logic [SZ_W-1:0]           col_q,     col_d;
    logic                      valid_q,   valid_d;
    logic [DATA_WIDTH-1:0]     data_q,    data_d;
    logic                      sat_q,     sat_d;
    logic                      last_q,    last_d;
    logic                      dropped_q, dropped_d;

    logic                      w_idle;
    logic                      w_hs;
    logic [SZ_W-1:0]           w_size_in;
    logic [SH_W-1:0]           w_shift_in;
    logic [SZ_W-1:0]           w_last_ix;
    logic [SZ_W-1:0]           w_nrow;
    logic [SZ_W-1:0]           w_ncol;
    logic                      w_nlast;
    logic [NE*ACC_WIDTH-1:0]   w_src;
    logic [ACC_WIDTH-1:0]      w_elems [NE];
    logic [IX_W-1:0]           w_idx;
    logic [SH_W-1:0]           w_shift;
    logic [DATA_WIDTH-1:0]     w_q;
    logic                      w_sat;

    assign w_idle     = (state_q == IDLE);
    assign w_hs       = valid_q & out_ready;
    assign w_size_in  = (in_size > C_SIZE) ? C_SIZE : in_size;
    assign w_shift_in = (shift_amt > C_SH_MAX) ? C_SH_MAX : shift_amt;
    assign w_last_ix  = (w_idle ? w_size_in : size_q) - SZ_W'(1);

    // In IDLE the requantizer looks at element (0,0) of the incoming matrix
    // so the first beat can be registered on the capture edge itself.
    always_comb begin
        w_nrow = '0;
        w_ncol = '0;
        if (!w_idle) begin
            if (col_q == w_last_ix) begin
                w_nrow = row_q + SZ_W'(1);
            end else begin
                w_nrow = row_q;
                w_ncol = col_q + SZ_W'(1);
            end
        end
    end

    assign w_nlast = (w_nrow == w_last_ix) && (w_ncol == w_last_ix);
    assign w_src   = w_idle ? in_matrix : matrix_q;
    assign w_shift = w_idle ? w_shift_in : shift_q;
    assign w_idx   = IX_W'(elem_idx(int'(w_nrow), int'(w_ncol), SIZE));

    for (genvar gi = 0; gi < NE; gi++) begin : g_unpack
        assign w_elems[gi] = w_src[gi*ACC_WIDTH +: ACC_WIDTH];
    end

    requant_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SHIFT_W    (SH_W)
    ) u_requant (
        .acc   (w_elems[w_idx]),
        .shift (w_shift),
        .q     (w_q),
        .sat   (w_sat)
    );

    always_comb begin
        state_d   = state_q;
        matrix_d  = matrix_q;
        size_d    = size_q;
        shift_d   = shift_q;
        row_d     = row_q;
        col_d     = col_q;
        valid_d   = valid_q;
        data_d    = data_q;
        sat_d     = sat_q;
        last_d    = last_q;
        dropped_d = dropped_q;

        case (state_q)
            IDLE: begin
                if (in_valid && (in_size != '0)) begin
                    matrix_d = in_matrix;
                    size_d   = w_size_in;
                    shift_d  = w_shift_in;
                    row_d    = '0;
                    col_d    = '0;
                    state_d  = DRAIN;
                    valid_d  = 1'b1;
                    data_d   = w_q;
                    sat_d    = w_sat;
                    last_d   = w_nlast;
                end
            end
            DRAIN: begin
                if (in_valid) begin
                    dropped_d = 1'b1;
                end
                if (w_hs) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        row_d  = w_nrow;
                        col_d  = w_ncol;
                        data_d = w_q;
                        sat_d  = w_sat;
                        last_d = w_nlast;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            matrix_q  <= '0;
            size_q    <= '0;
            shift_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            sat_q     <= 1'b0;
            last_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            matrix_q  <= matrix_d;
            size_q    <= size_d;
            shift_q   <= shift_d;
            row_q     <= row_d;
            col_q     <= col_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            sat_q     <= sat_d;
            last_q    <= last_d;
            dropped_q <= dropped_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_sat   = sat_q;
    assign busy      = (state_q == DRAIN);
    assign dropped   = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_result_drain_requant.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_result_drain_requant : self-checking bench for result_drain_requant
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_result_drain_requant;

    localparam int SIZE = 4;
    localparam int DW   = 8;
    localparam int AW   = 24;
    localparam int NE   = SIZE * SIZE;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [NE*AW-1:0] in_matrix;
    logic [2:0]      in_size;
    logic [4:0]      shift_amt;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            out_sat;
    logic            busy;
    logic            dropped;

    int n_checks = 0;
    int n_fail   = 0;
    int elems [NE];
    int exp_q [$];
    bit exp_s [$];

    typedef struct {
        int acc;
        int shift;
        int q;
        bit sat;
    } vec_t;

    vec_t vt [16];

    always #5 clk = ~clk;

    result_drain_requant #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_matrix (in_matrix),
        .in_size   (in_size),
        .shift_amt (shift_amt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_sat   (out_sat),
        .busy      (busy),
        .dropped   (dropped)
    );

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: floor((a + 2^(s-1)) / 2^s) with the shift clamped to AW-1.
    function automatic longint ref_t(input longint a, input int s);
        int se;
        se = (s > AW - 1) ? AW - 1 : s;
        if (se == 0) return a;
        return (a + (longint'(1) <<< (se - 1))) >>> se;
    endfunction

    task automatic build_expected(input int size, input int shift);
        int n;
        longint t;
        n = (size > SIZE) ? SIZE : size;
        exp_q.delete();
        exp_s.delete();
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                t = ref_t(longint'(elems[r*SIZE+c]), shift);
                if (t > 127) begin
                    exp_q.push_back(127);  exp_s.push_back(1'b1);
                end else if (t < -128) begin
                    exp_q.push_back(-128); exp_s.push_back(1'b1);
                end else begin
                    exp_q.push_back(int'(t)); exp_s.push_back(1'b0);
                end
            end
        end
    endtask

    function automatic logic [NE*AW-1:0] pack();
        logic [NE*AW-1:0] m;
        m = '0;
        for (int i = 0; i < NE; i++) m[i*AW +: AW] = AW'(elems[i]);
        return m;
    endfunction

    task automatic capture(input int size, input int shift);
        in_matrix = pack();
        in_size   = 3'(size);
        shift_amt = 5'(shift);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    // Consumes exp_q.size() beats; optional random backpressure and
    // strobe injection on beat 5 and on the final handshake.
    task automatic drain(input string tag, input bit rand_ready, input bit inject);
        int n;
        int beats;
        int cyc;
        bit stalled;
        bit rdy;
        logic [DW-1:0] held;
        n = exp_q.size();
        beats = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (beats < n && cyc < 400) begin
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            in_valid  = 1'b0;
            if (stalled) check({tag, " stall_hold"}, out_data, held);
            check({tag, " valid"}, out_valid, 1);
            if (out_valid) begin
                if (inject && (beats == 4 || (rdy && out_last))) begin
                    in_valid  = 1'b1;
                    in_matrix = ~in_matrix;
                    in_size   = 3'd4;
                end
                if (rdy) begin
                    check({tag, " data"}, $signed(out_data), exp_q[beats]);
                    check({tag, " sat"}, out_sat, exp_s[beats]);
                    check({tag, " last"}, out_last, (beats == n - 1));
                    check({tag, " busy"}, busy, 1);
                    beats++;
                end
                stalled = !rdy;
                held    = out_data;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (beats < n) check({tag, " beat_count"}, beats, n);
        check({tag, " end_last"}, out_last, 0);
        check({tag, " end_busy"}, busy, 0);
        for (int k = 0; k < 3; k++) begin
            check({tag, " idle_valid"}, out_valid, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_matrix = '0; in_size = '0; shift_amt = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst out_data",  out_data, 0);
        check("rst out_last",  out_last, 0);
        check("rst out_sat",   out_sat, 0);
        check("rst busy",      busy, 0);
        check("rst dropped",   dropped, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single-element captures (size 1) exercising requantization.
        vt[0]  = '{300, 0, 127, 1'b1};
        vt[1]  = '{-300, 0, -128, 1'b1};
        vt[2]  = '{5, 1, 3, 1'b0};
        vt[3]  = '{-5, 1, -2, 1'b0};
        vt[4]  = '{7, 2, 2, 1'b0};
        vt[5]  = '{127, 0, 127, 1'b0};
        vt[6]  = '{-128, 0, -128, 1'b0};
        vt[7]  = '{128, 0, 127, 1'b1};
        vt[8]  = '{-129, 0, -128, 1'b1};
        vt[9]  = '{255, 1, 127, 1'b1};
        vt[10] = '{-257, 1, -128, 1'b0};
        vt[11] = '{-6, 2, -1, 1'b0};
        vt[12] = '{4194304, 31, 1, 1'b0};
        vt[13] = '{8388607, 23, 1, 1'b0};
        vt[14] = '{-8388608, 23, -1, 1'b0};
        vt[15] = '{3, 1, 2, 1'b0};
        for (int v = 0; v < 16; v++) begin
            for (int i = 0; i < NE; i++) elems[i] = 0;
            elems[0] = vt[v].acc;
            exp_q.delete(); exp_s.delete();
            exp_q.push_back(vt[v].q);
            exp_s.push_back(vt[v].sat);
            capture(1, vt[v].shift);
            drain("vec", 1'b0, 1'b0);
        end

        for (int i = 0; i < NE; i++) elems[i] = i;
        build_expected(4, 0);
        capture(4, 0);
        drain("full", 1'b0, 1'b0);

        for (int i = 0; i < NE; i++) elems[i] = i * 10 + 1;
        build_expected(2, 0);
        capture(2, 0);
        drain("partial", 1'b0, 1'b0);

        for (int i = 0; i < NE; i++) elems[i] = i;
        build_expected(4, 0);
        capture(4, 0);
        drain("backpressure", 1'b1, 1'b0);
        check("dropped before", dropped, 0);

        capture(4, 0);
        drain("dropped", 1'b0, 1'b1);
        check("dropped sticky", dropped, 1);

        // Reset in the middle of a burst.
        for (int i = 0; i < NE; i++) elems[i] = 100 + i;
        build_expected(4, 0);
        capture(4, 0);
        for (int k = 0; k < 6; k++) begin
            out_ready = 1'b1;
            check("midrst data", $signed(out_data), exp_q[k]);
            check("midrst valid", out_valid, 1);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst out_valid", out_valid, 0);
        check("midrst busy", busy, 0);
        check("midrst dropped", dropped, 0);
        for (int i = 0; i < NE; i++) elems[i] = i;
        build_expected(4, 0);
        capture(4, 0);
        drain("after_rst", 1'b0, 1'b0);

        for (int it = 0; it < 24; it++) begin
            int sz;
            int sh;
            sz = (it == 0) ? 7 : (it == 1) ? 0 : int'($urandom_range(0, 7));
            sh = int'($urandom_range(0, 31));
            for (int i = 0; i < NE; i++)
                elems[i] = int'($signed(24'($urandom))) >>> $urandom_range(0, 23);
            build_expected(sz, sh);
            capture(sz, sh);
            drain("rand", 1'b1, 1'b0);
        end
        check("rand dropped", dropped, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
